// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format select encoding and
// shift-amount width per XLEN.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_RSV = 3'b111
  } imm_sel_e;

  function automatic int unsigned shamt_w(input int unsigned xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for every RV base format plus zimm and shamt.
// IMM_GEN_ERR_EN adds o_err flagging reserved selects and out-of-range RV32 shamts.
import imm_pkg::*;

module imm_decode #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_sel,
  output logic [XLEN-1:0] o_imm
`ifdef IMM_GEN_ERR_EN
  ,
  output logic            o_err
`endif
);

  localparam int unsigned ShW = shamt_w(XLEN);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  imm_sel_e w_sel;
  logic     w_s;
  logic     w_unused_opcode;

  assign w_sel           = imm_sel_e'(i_sel);
  assign w_s             = i_instr[31];
  assign w_unused_opcode = ^i_instr[6:0];

  always_comb begin
    o_imm = '0;
    case (w_sel)
      IMM_I:   o_imm = {{(XLEN-11){w_s}}, i_instr[30:20]};
      IMM_S:   o_imm = {{(XLEN-11){w_s}}, i_instr[30:25], i_instr[11:7]};
      IMM_B:   o_imm = {{(XLEN-12){w_s}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J:   o_imm = {{(XLEN-20){w_s}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      IMM_U:   o_imm = {{(XLEN-31){w_s}}, i_instr[30:12], 12'b0};
      IMM_Z:   o_imm = {{(XLEN-5){1'b0}}, i_instr[19:15]};
      IMM_SH:  o_imm = {{(XLEN-ShW){1'b0}}, i_instr[20+ShW-1:20]};
      default: o_imm = '0;
    endcase
  end

`ifdef IMM_GEN_ERR_EN
  // RV32 shamt is 5 bits, so a set i[25] is an illegal shift encoding there.
  assign o_err = (w_sel == IMM_RSV) || ((w_sel == IMM_SH) && (XLEN == 32) && i_instr[25]);
`endif

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a main (M) and skid (K) register on a valid/ready
// handshake; define IMM_GEN_ERR_EN to carry an out_err flag with each entry.
import imm_pkg::*;

module imm_gen_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ERR_EN
  ,
  output logic             out_err
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ERR_EN
    logic             err;
`endif
  } payload_t;

  payload_t        r_m, r_k, w_m_next, w_k_next, w_new;
  logic            r_m_valid, r_k_valid, w_m_valid_next, w_k_valid_next;
  logic            w_accept, w_drain;
  logic [XLEN-1:0] w_imm;
`ifdef IMM_GEN_ERR_EN
  logic            w_err;
`endif

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_instr (in_instr),
    .i_sel   (in_sel),
    .o_imm   (w_imm)
`ifdef IMM_GEN_ERR_EN
    ,
    .o_err   (w_err)
`endif
  );

  always_comb begin
    w_new     = '0;
    w_new.imm = w_imm;
    w_new.tag = in_tag;
`ifdef IMM_GEN_ERR_EN
    w_new.err = w_err;
`endif
  end

  assign w_accept = in_valid && !r_k_valid;
  assign w_drain  = r_m_valid && out_ready;

  always_comb begin
    w_m_next       = r_m;
    w_k_next       = r_k;
    w_m_valid_next = r_m_valid;
    w_k_valid_next = r_k_valid;
    if (flush) begin
      w_m_valid_next = 1'b0;
      w_k_valid_next = 1'b0;
    end else if (w_drain) begin
      if (r_k_valid) begin
        w_m_next       = r_k;
        w_m_valid_next = 1'b1;
        w_k_valid_next = w_accept;
        if (w_accept) w_k_next = w_new;
      end else if (w_accept) begin
        w_m_next = w_new;
      end else begin
        w_m_valid_next = 1'b0;
      end
    end else if (w_accept) begin
      // K only fills while M is stalled, so M always holds the oldest entry.
      if (!r_m_valid) begin
        w_m_next       = w_new;
        w_m_valid_next = 1'b1;
      end else begin
        w_k_next       = w_new;
        w_k_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_m       <= '0;
      r_k       <= '0;
      r_m_valid <= 1'b0;
      r_k_valid <= 1'b0;
    end else begin
      r_m       <= w_m_next;
      r_k       <= w_k_next;
      r_m_valid <= w_m_valid_next;
      r_k_valid <= w_k_valid_next;
    end
  end

  assign in_ready  = !r_k_valid;
  assign out_valid = r_m_valid;
  assign out_imm   = r_m.imm;
  assign out_tag   = r_m.tag;
`ifdef IMM_GEN_ERR_EN
  assign out_err   = r_m.err;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances on shared stimulus, a format
// table, hand-written handshake/flush/reset sequences and a randomized FIFO-model run.
module tb_imm_gen_stage;

  localparam int unsigned TagW = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [31:0]     in_instr = '0;
  logic [2:0]      in_sel = '0;
  logic [TagW-1:0] in_tag = '0;

  logic            rdy32, rdy64, ov32, ov64;
  logic [31:0]     imm32;
  logic [63:0]     imm64;
  logic [TagW-1:0] tag32, tag64;
`ifdef IMM_GEN_ERR_EN
  logic            err32, err64;
`endif

  imm_gen_stage #(.XLEN(32), .TAG_W(TagW)) dut32 (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy32),
    .in_instr  (in_instr),
    .in_sel    (in_sel),
    .in_tag    (in_tag),
    .out_valid (ov32),
    .out_ready (out_ready),
    .out_imm   (imm32),
    .out_tag   (tag32)
`ifdef IMM_GEN_ERR_EN
    ,
    .out_err   (err32)
`endif
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(TagW)) dut64 (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy64),
    .in_instr  (in_instr),
    .in_sel    (in_sel),
    .in_tag    (in_tag),
    .out_valid (ov64),
    .out_ready (out_ready),
    .out_imm   (imm64),
    .out_tag   (tag64)
`ifdef IMM_GEN_ERR_EN
    ,
    .out_err   (err64)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0]     instr;
    logic [2:0]      sel;
    logic [TagW-1:0] tag;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] e32;
    logic [63:0] e64;
    bit          err32;
    bit          err64;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference immediate as a signed integer value, built from field positions.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                          input bit x64);
    longint v;
    case (sel)
      3'd0: v = longint'($signed(ins)) >>> 20;
      3'd1: v = (longint'($signed(ins)) >>> 25) * 32 + longint'(ins[11:7]);
      3'd2: v = longint'({ins[7], ins[30:25], ins[11:8], 1'b0}) - (ins[31] ? 4096 : 0);
      3'd3: v = longint'({ins[19:12], ins[20], ins[30:21], 1'b0}) - (ins[31] ? 1048576 : 0);
      3'd4: v = (longint'($signed(ins)) >>> 12) * 4096;
      3'd5: v = longint'(ins[19:15]);
      3'd6: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit ref_err(input logic [31:0] ins, input logic [2:0] sel, input bit x64);
    return (sel == 3'd7) || (!x64 && sel == 3'd6 && ins[25]);
  endfunction

  task automatic check_state();
    logic [63:0] e;
    check("in_ready32", rdy32, q.size() < 2);
    check("in_ready64", rdy64, q.size() < 2);
    check("out_valid32", ov32, q.size() > 0);
    check("out_valid64", ov64, q.size() > 0);
    if (q.size() > 0) begin
      e = ref_imm(q[0].instr, q[0].sel, 1'b0);
      check("out_imm32", imm32, e[31:0]);
      check("out_imm64", imm64, ref_imm(q[0].instr, q[0].sel, 1'b1));
      check("out_tag32", tag32, q[0].tag);
      check("out_tag64", tag64, q[0].tag);
`ifdef IMM_GEN_ERR_EN
      check("out_err32", err32, ref_err(q[0].instr, q[0].sel, 1'b0));
      check("out_err64", err64, ref_err(q[0].instr, q[0].sel, 1'b1));
`endif
    end
  endtask

  // Called at a falling edge: check, drive, advance the model across the next rising edge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] sel,
                      input logic [TagW-1:0] tag, input bit ordy, input bit fl);
    bit acc;
    bit drn;
    check_state();
    in_valid  = v;
    in_instr  = ins;
    in_sel    = sel;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    if (fl) begin
      q.delete();
    end else begin
      acc = v && (q.size() < 2);
      drn = (q.size() > 0) && ordy;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{instr: ins, sel: sel, tag: tag});
    end
    @(negedge clock);
  endtask

  initial begin
    tbl.push_back('{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0});
    tbl.push_back('{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000_000007FF, 1'b0, 1'b0});
    tbl.push_back('{32'h00A12423, 3'd1, 32'h00000008, 64'h00000000_00000008, 1'b0, 1'b0});
    tbl.push_back('{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b0});
    tbl.push_back('{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b0});
    tbl.push_back('{32'h00000463, 3'd2, 32'h00000008, 64'h00000000_00000008, 1'b0, 1'b0});
    tbl.push_back('{32'h800000EF, 3'd3, 32'hFFF00000, 64'hFFFFFFFF_FFF00000, 1'b0, 1'b0});
    tbl.push_back('{32'h800002B7, 3'd4, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0, 1'b0});
    tbl.push_back('{32'h800F8073, 3'd5, 32'h0000001F, 64'h00000000_0000001F, 1'b0, 1'b0});
    tbl.push_back('{32'h03F00013, 3'd6, 32'h0000001F, 64'h00000000_0000003F, 1'b1, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h00000000_00000000, 1'b1, 1'b1});

    // Reset values while reset is held.
    @(negedge clock);
    check("rst_out_valid", ov32, 1'b0);
    check("rst_in_ready", rdy32, 1'b1);
    check("rst_out_imm32", imm32, 32'h0);
    check("rst_out_imm64", imm64, 64'h0);
    check("rst_out_tag", tag32, 5'h0);
    reset = 1'b0;
    @(negedge clock);

    // Format table, back-to-back with out_ready high: one result per cycle.
    for (int k = 0; k < tbl.size(); k++) begin
      in_valid  = 1'b1;
      in_instr  = tbl[k].instr;
      in_sel    = tbl[k].sel;
      in_tag    = TagW'(k);
      out_ready = 1'b1;
      @(negedge clock);
      check("tbl_valid", ov32, 1'b1);
      check("tbl_imm32", imm32, tbl[k].e32);
      check("tbl_imm64", imm64, tbl[k].e64);
      check("tbl_tag", tag32, TagW'(k));
`ifdef IMM_GEN_ERR_EN
      check("tbl_err32", err32, tbl[k].err32);
      check("tbl_err64", err64, tbl[k].err64);
`endif
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("tbl_drained", ov32, 1'b0);

    // Back-pressure: three offered with out_ready low, only two captured.
    step(1'b1, 32'h00100093, 3'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 3'd0, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 3'd0, 5'd2, 1'b0, 1'b0);
    check("bp_ready_low", rdy32, 1'b0);
    check("bp_head0", tag32, 5'd0);
    step(1'b1, 32'h00300093, 3'd0, 5'd2, 1'b1, 1'b0);
    check("bp_head1", tag32, 5'd1);
    step(1'b1, 32'h00300093, 3'd0, 5'd2, 1'b1, 1'b0);
    check("bp_head2", tag32, 5'd2);
    check("bp_imm2", imm32, 32'h3);
    step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // Flush with M and K full and a same-cycle offer.
    step(1'b1, 32'h00500093, 3'd0, 5'd5, 1'b0, 1'b0);
    step(1'b1, 32'h00600093, 3'd0, 5'd6, 1'b0, 1'b0);
    step(1'b1, 32'h00700093, 3'd0, 5'd7, 1'b0, 1'b1);
    check("flush_out_valid", ov32, 1'b0);
    check("flush_in_ready", rdy32, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges.
    step(1'b1, 32'h00900093, 3'd0, 5'd9, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid32", ov32, 1'b0);
    check("arst_out_valid64", ov64, 1'b0);
    check("arst_in_ready", rdy32, 1'b1);
    check("arst_out_imm", imm32, 32'h0);
    check("arst_out_tag", tag32, 5'h0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 32'hFFF00093, 3'd0, 5'd3, 1'b1, 1'b0);
    check("post_rst_valid", ov32, 1'b1);
    check("post_rst_imm", imm32, 32'hFFFFFFFF);
    step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // Randomized traffic against the FIFO model.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
           TagW'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
